// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states, default widths and the carrier
// constant that keeps the PWM generator and pwm_capture in agreement.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_e;

  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 65535;

  // 25 MHz system clock / 25 kHz carrier
  localparam int PWM_CARRIER_CLKS = 1000;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous pin with registered-history
// edge detection; reusable for any JA input.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~s_d;
  assign fall  = ~level & s_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: times each rising-to-rising cycle, holds high time and period
// until acknowledged, and flags overrun and stuck-input conditions.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  input  logic             rd_ack,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             valid,
  output logic             overrun,
  output logic             stuck,
  output logic             level
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  pwm_state_e       state, state_nxt;
  logic [CNT_W-1:0] hcnt, pcnt, idle_cnt;
  logic [CNT_W-1:0] hcnt_inc, pcnt_inc;
  logic             rise, fall, edge_seen, timeout, publish;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .din   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign edge_seen = rise | fall;
  assign timeout   = enable & ~edge_seen & (idle_cnt == IDLE_MAX);
  assign publish   = enable & (state == LOW) & rise;
  assign hcnt_inc  = (hcnt == CNT_MAX) ? hcnt : hcnt + ONE;
  assign pcnt_inc  = (pcnt == CNT_MAX) ? pcnt : pcnt + ONE;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable || timeout) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (rise) state_nxt = HIGH;
        HIGH:    if (fall) state_nxt = LOW;
        LOW:     if (rise) state_nxt = HIGH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // The rise clock opens the new cycle (count 1); the fall clock is the
  // HIGH->LOW hand-over and advances neither counter, so a high of H clocks
  // and low of L clocks reads back as H and H+L.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hcnt <= '0;
      pcnt <= '0;
    end else if (state_nxt == IDLE) begin
      hcnt <= '0;
      pcnt <= '0;
    end else if (rise) begin
      hcnt <= ONE;
      pcnt <= ONE;
    end else if (state == HIGH && !fall) begin
      hcnt <= hcnt_inc;
      pcnt <= pcnt_inc;
    end else if (state == LOW) begin
      pcnt <= pcnt_inc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
      stuck    <= 1'b0;
    end else begin
      if (!enable || edge_seen)    idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + ONE;
      if (edge_seen)    stuck <= 1'b0;
      else if (timeout) stuck <= 1'b1;
    end
  end

  // Result registers survive enable=0; only reset clears them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
    end else if (publish) begin
      high_cnt   <= hcnt;
      period_cnt <= pcnt_inc;
      valid      <= 1'b1;
      if (valid && !rd_ack) overrun <= 1'b1;
    end else if (rd_ack) begin
      if (valid) valid   <= 1'b0;
      else       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: waveform-level reference model of the
// measured high time/period plus the valid/overrun handshake.
module tb_pwm_capture;

  localparam int CW   = 7;
  localparam int TO   = 100;
  localparam int MAXC = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b1;
  logic          pwm_in = 1'b0;
  logic          rd_ack = 1'b0;
  logic [CW-1:0] high_cnt, period_cnt;
  logic          valid, overrun, stuck, level;

  int checks = 0;
  int failures = 0;

  // reference model: meas = a rise has been seen while measuring
  bit meas = 1'b0;
  int ph = 0, pl = 0;
  bit mv = 1'b0, mo = 1'b0;
  int mh = 0, mp = 0;

  pwm_capture #(
    .CNT_W       (CW),
    .SYNC_STAGES (2),
    .TIMEOUT     (TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .rd_ack     (rd_ack),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .valid      (valid),
    .overrun    (overrun),
    .stuck      (stuck),
    .level      (level)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x > MAXC) ? MAXC : x;
  endfunction

  // One PWM cycle: high h clocks, low l clocks. ack: 0 none, 1 ack the clock
  // after the publish, 2 ack in the publish clock. drop: enable low briefly
  // during the high phase.
  task automatic run_cycle(input int h, input int l, input int ack, input bit drop);
    bit pub;
    int eh, ep, done;
    pub = meas;
    eh  = sat(ph);
    ep  = sat(ph + pl);
    pwm_in = 1'b1;
    tick(); tick();
    if (ack == 2) rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    if (pub) begin
      if (mv && ack != 2) mo = 1'b1;
      mv = 1'b1; mh = eh; mp = ep;
    end else if (ack == 2) begin
      if (mv) mv = 1'b0; else mo = 1'b0;
    end
    chk("pub_high", high_cnt, mh);
    chk("pub_period", period_cnt, mp);
    chk("pub_valid", valid, mv);
    chk("pub_overrun", overrun, mo);
    chk("level_hi", level, 1);
    done = 3;
    if (ack == 1) begin
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      done++;
      if (mv) mv = 1'b0; else mo = 1'b0;
      chk("ack_valid", valid, mv);
      chk("ack_overrun", overrun, mo);
    end
    if (drop) begin
      enable = 1'b0;
      tick(); tick();
      done += 2;
      chk("drop_high", high_cnt, mh);
      chk("drop_period", period_cnt, mp);
      chk("drop_valid", valid, mv);
      enable = 1'b1;
    end
    repeat (h - done) tick();
    chk("stuck_high", stuck, (h > TO) ? 1 : 0);
    meas = !(drop || h > TO);
    ph = h;
    pl = l;
    pwm_in = 1'b0;
    repeat (l) tick();
    chk("stuck_low", stuck, 0);
    chk("level_lo", level, 0);
  endtask

  task automatic ack_pulse();
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    pl += 1;
    if (mv) mv = 1'b0; else mo = 1'b0;
    chk("ackp_valid", valid, mv);
    chk("ackp_overrun", overrun, mo);
  endtask

  initial begin
    // reset held while the pin toggles
    for (int i = 0; i < 20; i++) begin
      pwm_in = i[2];
      tick();
      if (i % 5 == 4) begin
        chk("rst_valid", valid, 0);
        chk("rst_high", high_cnt, 0);
        chk("rst_period", period_cnt, 0);
        chk("rst_level", level, 0);
        chk("rst_ovr_stuck", {overrun, stuck}, 0);
      end
    end
    pwm_in = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("post_rst_valid", valid, 0);

    // square wave 10/30; first cycle discarded
    run_cycle(10, 30, 0, 0);
    run_cycle(10, 30, 1, 0);
    run_cycle(10, 30, 1, 0);
    chk("sq_high", high_cnt, 10);
    chk("sq_period", period_cnt, 40);

    // two unacknowledged publishes -> overrun, then clear
    run_cycle(12, 20, 0, 0);
    run_cycle(7, 25, 0, 0);
    run_cycle(9, 15, 0, 0);
    chk("ovr_set", overrun, 1);
    ack_pulse();
    ack_pulse();
    chk("ovr_clr", overrun, 0);

    // publish with rd_ack in the same clock
    run_cycle(14, 18, 0, 0);
    run_cycle(11, 22, 2, 0);
    chk("same_valid", valid, 1);
    chk("same_ovr", overrun, 0);

    // period saturation
    run_cycle(60, 80, 1, 0);
    run_cycle(10, 10, 1, 0);
    chk("sat_period", period_cnt, MAXC);

    // stuck high, then restart from idle
    run_cycle(TO + 10, 20, 1, 0);
    run_cycle(12, 20, 0, 0);
    run_cycle(12, 20, 1, 0);

    // enable dropped mid-high; next cycle discarded
    run_cycle(16, 20, 0, 1);
    run_cycle(12, 20, 0, 0);
    run_cycle(13, 21, 1, 0);

    // randomized cycles and handshakes
    for (int i = 0; i < 24; i++) begin
      run_cycle(int'($urandom_range(40, 8)), int'($urandom_range(40, 4)),
                int'($urandom_range(2, 0)), 1'b0);
      if ($urandom_range(3, 0) == 0) ack_pulse();
    end

    // async reset in the middle of a low phase
    run_cycle(10, 10, 0, 0);
    pwm_in = 1'b1;
    repeat (12) tick();
    pwm_in = 1'b0;
    repeat (6) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("async_high", high_cnt, 0);
    chk("async_period", period_cnt, 0);
    chk("async_valid", valid, 0);
    chk("async_ovr_stuck", {overrun, stuck}, 0);
    chk("async_level", level, 0);
    tick();
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the regfile's PWM output path: measures an external PWM waveform and presents high-time and period as processor-readable words.
- Sits beside the regfile, fed from a JA pin and clocked on the 25 MHz system clock.
- Synchronises the input, detects edges, times each full cycle rising-to-rising, and holds the result until the consumer acknowledges it.
- Flags a stuck input (no edges) and lost results (overrun).

Parameters:
- CNT_W, 16, width of the high-time and period counters in clock cycles.
- SYNC_STAGES, 2, flip-flop synchroniser depth on pwm_in; minimum 2.
- TIMEOUT, 65535, cycles without any edge before the stuck condition; must be at most 2^CNT_W-1.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- enable  in  1  1 = measuring; 0 = return to IDLE, keep held outputs.
- pwm_in  in  1  external PWM input, asynchronous to clock.
- rd_ack  in  1  one-cycle pulse: consumer has read the result; clears valid.
- high_cnt  out  CNT_W  high time of the last complete cycle, in clocks.
- period_cnt  out  CNT_W  period of the last complete cycle, in clocks.
- valid  out  1  a new result is held and not yet acknowledged.
- overrun  out  1  sticky: a result was overwritten while valid=1.
- stuck  out  1  no edge for TIMEOUT cycles while enabled.
- level  out  1  synchronised pwm_in value.

Behaviour:
- Reset (reset=0): high_cnt=0, period_cnt=0, valid=0, overrun=0, stuck=0, level=0, synchroniser=0, state=IDLE, counters=0.
- Synchroniser: pwm_in passes through SYNC_STAGES flops; s = last stage, s_d = s delayed one clock.
  - rise = s & ~s_d; fall = ~s & s_d.
  - level = s.
  - Edge-to-detect latency is SYNC_STAGES+1 clocks.
- Counters:
  - hcnt and pcnt each saturate at 2^CNT_W-1 and never wrap.
  - idle_cnt counts clocks since the last edge and saturates at TIMEOUT.
- State machine:
  - IDLE: counters cleared. Go to HIGH on rise while enable=1. The first partial cycle is discarded.
  - HIGH: pcnt++ and hcnt++ each clock. Go to LOW on fall.
  - LOW: pcnt++ each clock. On rise:
    - publish high_cnt <= hcnt and period_cnt <= pcnt+1, counting the edge clock;
    - set valid;
    - hcnt <= 1, pcnt <= 1;
    - stay in HIGH (i.e. go to HIGH).
  - Any state with enable=0: go to IDLE next clock. valid, high_cnt, period_cnt and overrun are kept.
- Publish and acknowledge:
  - Publish while valid=1 and no rd_ack in the same cycle sets overrun=1; new data replaces the old.
  - Publish and rd_ack in the same cycle: new data, valid stays 1, overrun unchanged.
  - rd_ack with no publish: valid <= 0.
  - overrun clears only on reset, or on rd_ack while valid=0.
- Stuck detection:
  - idle_cnt resets on any rise or fall.
  - When idle_cnt reaches TIMEOUT with enable=1: stuck=1 and state goes to IDLE (0% or 100% duty).
  - stuck clears on the next edge; that edge behaves as from IDLE, so only a rise starts a measurement.
- A saturated count is published as the saturated value; nothing wraps.
- Reset mid-cycle: the partial measurement is lost and all outputs take their reset values.

Decomposition:
- Shared package pwm_pkg holds:
  - the state enum IDLE/HIGH/LOW (2-bit);
  - default localparams CNT_W=16, TIMEOUT=65535;
  - the PWM carrier constant, also used by the PWM generator, so TX and RX agree.
- One natural sub-module: sync_edge_det.
  - Contains the SYNC_STAGES synchroniser plus the rise/fall/level outputs.
  - Reusable for the other JA inputs.

Test Plan:
- Reset: hold reset=0 while pwm_in toggles -> all outputs 0, valid never rises; release -> still 0 until two rising edges have been seen.
- Square wave high 10 / low 30 clocks, enable=1 -> first valid after the second rise; high_cnt=10, period_cnt=40; subsequent results identical.
- Handshake: pulse rd_ack one clock after valid -> valid=0 next clock. Skip rd_ack for two publishes -> overrun=1 and the registers hold the newest values. Then rd_ack with valid=0 -> overrun=0.
- Simultaneous publish and rd_ack in the same cycle -> valid stays 1, overrun stays 0, new values present.
- Hold pwm_in=1 for TIMEOUT+5 clocks with TIMEOUT=100 -> stuck=1 at 100 clocks after the last edge. Next waveform -> stuck clears on the first edge, valid after two rises.
- enable dropped mid-HIGH -> state IDLE, previously held high_cnt/period_cnt/valid unchanged. Re-enable -> first partial cycle discarded. Async reset asserted mid-LOW -> outputs zero within the same cycle.
